// File: rtl/sdram_init_seq.sv
// ---------------------------------------------------------------------------
// sdram_init_seq
//   SDRAM power-up initialisation sequencer. Issues NOP for the power-up wait,
//   then PRECHARGE-ALL, AREF_NUM x AUTO-REFRESH, MODE REGISTER SET and an
//   optional EXTENDED MRS, each separated by its minimum command spacing.
//   Drives the controller command/address mux until flag_init; a re-init
//   request in DONE replays the sequence without the power-up wait.
//
// Ports
//   S_CLK      in   system clock
//   RST        in   asynchronous reset, active-high
//   init_req   in   re-init request pulse, honoured only in DONE
//   init_cmd   out  {CKE,CS_N,RAS_N,CAS_N,WE_N}
//   init_addr  out  SDRAM address for the current command
//   init_ba    out  SDRAM bank address for the current command
//   init_busy  out  sequence in progress (any state except DONE)
//   flag_init  out  initialisation complete
// ---------------------------------------------------------------------------
module sdram_init_seq #(
  parameter int unsigned        ADDR_W     = 12,
  parameter int unsigned        BA_W       = 2,
  parameter int unsigned        T_PWR_CYC  = 4000,
  parameter int unsigned        T_RP_CYC   = 2,
  parameter int unsigned        T_RFC_CYC  = 7,
  parameter int unsigned        T_MRD_CYC  = 2,
  parameter int unsigned        AREF_NUM   = 2,
  parameter logic [2:0]         BURST_LEN  = 3'b010,
  parameter logic               BURST_TYPE = 1'b0,
  parameter logic [2:0]         CAS_LAT    = 3'b010,
  parameter logic               WR_BURST   = 1'b0,
  parameter logic               EMRS_EN    = 1'b0,
  parameter logic [ADDR_W-1:0]  EMRS_VAL   = '0
) (
  input  logic              S_CLK,
  input  logic              RST,
  input  logic              init_req,
  output logic [4:0]        init_cmd,
  output logic [ADDR_W-1:0] init_addr,
  output logic [BA_W-1:0]   init_ba,
  output logic              init_busy,
  output logic              flag_init
);

  // Wait counter must hold the largest spacing value
  localparam int unsigned T_MAX_A = (T_PWR_CYC > T_RP_CYC)  ? T_PWR_CYC : T_RP_CYC;
  localparam int unsigned T_MAX_B = (T_RFC_CYC > T_MRD_CYC) ? T_RFC_CYC : T_MRD_CYC;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned CNT_W   = $clog2(T_MAX + 1);
  localparam int unsigned REF_W   = 4;

  localparam logic [4:0] CMD_NOP  = 5'b10111;
  localparam logic [4:0] CMD_PREC = 5'b10010;
  localparam logic [4:0] CMD_AREF = 5'b10001;
  localparam logic [4:0] CMD_MRS  = 5'b10000;

  localparam logic [ADDR_W-1:0] PREC_ADDR = ADDR_W'(11'h400);
  localparam logic [ADDR_W-1:0] MRS_ADDR  =
    ADDR_W'({WR_BURST, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN});
  localparam logic [BA_W-1:0]   EMRS_BA   = BA_W'(2'b10);

  localparam logic [3:0] S_WAIT_PWR = 4'd0;
  localparam logic [3:0] S_PREC     = 4'd1;
  localparam logic [3:0] S_WAIT_RP  = 4'd2;
  localparam logic [3:0] S_AREF     = 4'd3;
  localparam logic [3:0] S_WAIT_RFC = 4'd4;
  localparam logic [3:0] S_MRS      = 4'd5;
  localparam logic [3:0] S_WAIT_MRD = 4'd6;
  localparam logic [3:0] S_EMRS     = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [REF_W-1:0]  r_refs;
  logic              r_emrs_sent;
  logic [4:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [BA_W-1:0]   r_ba;
  logic              r_busy;
  logic              r_flag;

  logic [3:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [REF_W-1:0]  w_refs_nxt;
  logic              w_emrs_nxt;
  logic [4:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [BA_W-1:0]   w_ba;
  logic              w_refs_left;

  assign w_refs_left = (r_refs < REF_W'(AREF_NUM));

  // State register; r_cnt holds cycles elapsed since the last command
  always_ff @(posedge S_CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_WAIT_PWR;
      r_cnt       <= '0;
      r_refs      <= '0;
      r_emrs_sent <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_refs      <= w_refs_nxt;
      r_emrs_sent <= w_emrs_nxt;
    end
  end

  // Next-state logic; a spacing of 1 skips the wait state entirely
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_refs_nxt  = r_refs;
    w_emrs_nxt  = r_emrs_sent;
    case (r_state)
      S_WAIT_PWR: begin
        // r_cnt equals the current cycle number since reset release
        if (r_cnt == CNT_W'(T_PWR_CYC)) begin
          w_state_nxt = S_PREC;
          w_cnt_nxt   = '0;
          w_refs_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PREC: begin
        if (T_RP_CYC == 1) begin
          w_state_nxt = S_AREF;
          w_refs_nxt  = r_refs + REF_W'(1);
        end else begin
          w_state_nxt = S_WAIT_RP;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_WAIT_RP: begin
        if (r_cnt == CNT_W'(T_RP_CYC - 1)) begin
          w_state_nxt = S_AREF;
          w_cnt_nxt   = '0;
          w_refs_nxt  = r_refs + REF_W'(1);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_AREF: begin
        if (T_RFC_CYC == 1) begin
          if (w_refs_left) begin
            w_state_nxt = S_AREF;
            w_refs_nxt  = r_refs + REF_W'(1);
          end else begin
            w_state_nxt = S_MRS;
            w_emrs_nxt  = 1'b0;
          end
        end else begin
          w_state_nxt = S_WAIT_RFC;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_WAIT_RFC: begin
        if (r_cnt == CNT_W'(T_RFC_CYC - 1)) begin
          w_cnt_nxt = '0;
          if (w_refs_left) begin
            w_state_nxt = S_AREF;
            w_refs_nxt  = r_refs + REF_W'(1);
          end else begin
            w_state_nxt = S_MRS;
            w_emrs_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_MRS: begin
        if (T_MRD_CYC == 1) begin
          if (EMRS_EN) begin
            w_state_nxt = S_EMRS;
            w_emrs_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_WAIT_MRD;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_WAIT_MRD: begin
        // Shared by MRS and EMRS; r_emrs_sent says which one preceded
        if (r_cnt == CNT_W'(T_MRD_CYC - 1)) begin
          w_cnt_nxt = '0;
          if (EMRS_EN && !r_emrs_sent) begin
            w_state_nxt = S_EMRS;
            w_emrs_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_EMRS: begin
        if (T_MRD_CYC == 1) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT_MRD;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_DONE: begin
        if (init_req) begin
          w_state_nxt = S_PREC;
          w_cnt_nxt   = '0;
          w_refs_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_WAIT_PWR;
        w_cnt_nxt   = '0;
        w_refs_nxt  = '0;
        w_emrs_nxt  = 1'b0;
      end
    endcase
  end

  // Command decode of the upcoming state so outputs align with it
  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = '0;
    w_ba   = '0;
    case (w_state_nxt)
      S_PREC: begin
        w_cmd  = CMD_PREC;
        w_addr = PREC_ADDR;
      end
      S_AREF: w_cmd = CMD_AREF;
      S_MRS: begin
        w_cmd  = CMD_MRS;
        w_addr = MRS_ADDR;
      end
      S_EMRS: begin
        w_cmd  = CMD_MRS;
        w_addr = EMRS_VAL;
        w_ba   = EMRS_BA;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge S_CLK or posedge RST) begin
    if (RST) begin
      r_cmd  <= CMD_NOP;
      r_addr <= '0;
      r_ba   <= '0;
      r_busy <= 1'b1;
      r_flag <= 1'b0;
    end else begin
      r_cmd  <= w_cmd;
      r_addr <= w_addr;
      r_ba   <= w_ba;
      r_busy <= (w_state_nxt != S_DONE);
      r_flag <= (w_state_nxt == S_DONE);
    end
  end

  assign init_cmd  = r_cmd;
  assign init_addr = r_addr;
  assign init_ba   = r_ba;
  assign init_busy = r_busy;
  assign flag_init = r_flag;

endmodule

// File: tb/tb_sdram_init_seq.sv
// ---------------------------------------------------------------------------
// tb_sdram_init_seq
//   Directed bench for sdram_init_seq. Three instances: default parameters,
//   a short-timing configuration, and EMRS enabled. Outputs are sampled on
//   the falling edge; cycle k is the k-th rising edge after reset release.
// ---------------------------------------------------------------------------
module tb_sdram_init_seq;

  localparam logic [4:0] NOP  = 5'b10111;
  localparam logic [4:0] PREC = 5'b10010;
  localparam logic [4:0] AREF = 5'b10001;
  localparam logic [4:0] MRS  = 5'b10000;

  logic clk;
  logic rst_def, rst_fast, rst_emrs;
  logic req_def, req_fast, req_emrs;

  logic [4:0]  cmd_def, cmd_fast, cmd_emrs;
  logic [11:0] addr_def, addr_fast, addr_emrs;
  logic [1:0]  ba_def, ba_fast, ba_emrs;
  logic        busy_def, busy_fast, busy_emrs;
  logic        flag_def, flag_fast, flag_emrs;

  int n_tests;
  int n_fail;

  logic [4:0]  e_cmd;
  logic [11:0] e_addr;
  logic [1:0]  e_ba;
  logic        e_busy;
  logic        e_flag;

  sdram_init_seq u_def (
    .S_CLK(clk), .RST(rst_def), .init_req(req_def),
    .init_cmd(cmd_def), .init_addr(addr_def), .init_ba(ba_def),
    .init_busy(busy_def), .flag_init(flag_def)
  );

  sdram_init_seq #(
    .T_PWR_CYC(10), .T_RP_CYC(1), .T_RFC_CYC(3), .AREF_NUM(4), .T_MRD_CYC(1)
  ) u_fast (
    .S_CLK(clk), .RST(rst_fast), .init_req(req_fast),
    .init_cmd(cmd_fast), .init_addr(addr_fast), .init_ba(ba_fast),
    .init_busy(busy_fast), .flag_init(flag_fast)
  );

  sdram_init_seq #(
    .EMRS_EN(1'b1), .EMRS_VAL(12'h020)
  ) u_emrs (
    .S_CLK(clk), .RST(rst_emrs), .init_req(req_emrs),
    .init_cmd(cmd_emrs), .init_addr(addr_emrs), .init_ba(ba_emrs),
    .init_busy(busy_emrs), .flag_init(flag_emrs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({cmd_def, addr_def, ba_def, busy_def, flag_def} !== {NOP, 12'h000, 2'b00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_def got cmd=%b addr=%h ba=%b busy=%b flag=%b exp cmd=10111 addr=000 ba=00 busy=1 flag=0",
               cmd_def, addr_def, ba_def, busy_def, flag_def);
    end
    n_tests++;
    if ({cmd_fast, addr_fast, ba_fast, busy_fast, flag_fast} !== {NOP, 12'h000, 2'b00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_fast got cmd=%b addr=%h ba=%b busy=%b flag=%b", cmd_fast, addr_fast, ba_fast, busy_fast, flag_fast);
    end
    n_tests++;
    if ({cmd_emrs, addr_emrs, ba_emrs, busy_emrs, flag_emrs} !== {NOP, 12'h000, 2'b00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_emrs got cmd=%b addr=%h ba=%b busy=%b flag=%b", cmd_emrs, addr_emrs, ba_emrs, busy_emrs, flag_emrs);
    end
  endtask

  // Default config: full power-up sequence, every cycle checked
  task automatic test_power_up;
    rst_def = 1'b0;
    for (int k = 1; k <= 4025; k++) begin
      @(posedge clk);
      @(negedge clk);
      e_cmd = NOP; e_addr = 12'h000; e_ba = 2'b00;
      if (k == 4001) begin e_cmd = PREC; e_addr = 12'h400; end
      else if (k == 4003 || k == 4010) e_cmd = AREF;
      else if (k == 4017) begin e_cmd = MRS; e_addr = 12'h022; end
      e_flag = (k >= 4019);
      e_busy = !e_flag;
      n_tests++;
      if ({cmd_def, addr_def, ba_def, busy_def, flag_def} !== {e_cmd, e_addr, e_ba, e_busy, e_flag}) begin
        n_fail++;
        $display("FAIL power_up cyc=%0d got cmd=%b addr=%h ba=%b busy=%b flag=%b exp cmd=%b addr=%h ba=%b busy=%b flag=%b",
                 k, cmd_def, addr_def, ba_def, busy_def, flag_def, e_cmd, e_addr, e_ba, e_busy, e_flag);
      end
    end
  endtask

  // Short timings, back-to-back precharge/refresh and mode spacing of 1
  task automatic test_fast_timing;
    rst_fast = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      e_cmd = NOP; e_addr = 12'h000; e_ba = 2'b00;
      if (k == 11) begin e_cmd = PREC; e_addr = 12'h400; end
      else if (k == 12 || k == 15 || k == 18 || k == 21) e_cmd = AREF;
      else if (k == 24) begin e_cmd = MRS; e_addr = 12'h022; end
      e_flag = (k >= 25);
      e_busy = !e_flag;
      n_tests++;
      if ({cmd_fast, addr_fast, ba_fast, busy_fast, flag_fast} !== {e_cmd, e_addr, e_ba, e_busy, e_flag}) begin
        n_fail++;
        $display("FAIL fast_timing cyc=%0d got cmd=%b addr=%h ba=%b busy=%b flag=%b exp cmd=%b addr=%h ba=%b busy=%b flag=%b",
                 k, cmd_fast, addr_fast, ba_fast, busy_fast, flag_fast, e_cmd, e_addr, e_ba, e_busy, e_flag);
      end
    end
    // Reset while in DONE aborts immediately
    rst_fast = 1'b1;
    #1;
    n_tests++;
    if ({cmd_fast, addr_fast, ba_fast, busy_fast, flag_fast} !== {NOP, 12'h000, 2'b00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_in_done got cmd=%b addr=%h ba=%b busy=%b flag=%b exp cmd=10111 addr=000 ba=00 busy=1 flag=0",
               cmd_fast, addr_fast, ba_fast, busy_fast, flag_fast);
    end
    @(negedge clk);
  endtask

  task automatic test_emrs;
    rst_emrs = 1'b0;
    for (int k = 1; k <= 4025; k++) begin
      @(posedge clk);
      @(negedge clk);
      e_cmd = NOP; e_addr = 12'h000; e_ba = 2'b00;
      if (k == 4001) begin e_cmd = PREC; e_addr = 12'h400; end
      else if (k == 4003 || k == 4010) e_cmd = AREF;
      else if (k == 4017) begin e_cmd = MRS; e_addr = 12'h022; end
      else if (k == 4019) begin e_cmd = MRS; e_addr = 12'h020; e_ba = 2'b10; end
      e_flag = (k >= 4021);
      e_busy = !e_flag;
      n_tests++;
      if ({cmd_emrs, addr_emrs, ba_emrs, busy_emrs, flag_emrs} !== {e_cmd, e_addr, e_ba, e_busy, e_flag}) begin
        n_fail++;
        $display("FAIL emrs cyc=%0d got cmd=%b addr=%h ba=%b busy=%b flag=%b exp cmd=%b addr=%h ba=%b busy=%b flag=%b",
                 k, cmd_emrs, addr_emrs, ba_emrs, busy_emrs, flag_emrs, e_cmd, e_addr, e_ba, e_busy, e_flag);
      end
    end
  endtask

  // Re-init from DONE (pulse sampled at edge 1); a second pulse at edge 6 is ignored
  task automatic test_reinit;
    for (int k = 1; k <= 25; k++) begin
      req_def = (k == 1 || k == 6);
      @(posedge clk);
      @(negedge clk);
      req_def = 1'b0;
      e_cmd = NOP; e_addr = 12'h000; e_ba = 2'b00;
      if (k == 1) begin e_cmd = PREC; e_addr = 12'h400; end
      else if (k == 3 || k == 10) e_cmd = AREF;
      else if (k == 17) begin e_cmd = MRS; e_addr = 12'h022; end
      e_flag = (k >= 19);
      e_busy = !e_flag;
      n_tests++;
      if ({cmd_def, addr_def, ba_def, busy_def, flag_def} !== {e_cmd, e_addr, e_ba, e_busy, e_flag}) begin
        n_fail++;
        $display("FAIL reinit cyc=%0d got cmd=%b addr=%h ba=%b busy=%b flag=%b exp cmd=%b addr=%h ba=%b busy=%b flag=%b",
                 k, cmd_def, addr_def, ba_def, busy_def, flag_def, e_cmd, e_addr, e_ba, e_busy, e_flag);
      end
    end
  endtask

  // Reset between the two refreshes, then a complete power-up wait again
  task automatic test_reset_abort;
    rst_def = 1'b1;
    @(negedge clk);
    rst_def = 1'b0;
    for (int k = 1; k <= 4005; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4003) begin
        n_tests++;
        if (cmd_def !== AREF) begin
          n_fail++;
          $display("FAIL abort_pre_aref got cmd=%b exp cmd=%b", cmd_def, AREF);
        end
      end
    end
    rst_def = 1'b1;
    #1;
    n_tests++;
    if ({cmd_def, addr_def, ba_def, busy_def, flag_def} !== {NOP, 12'h000, 2'b00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_immediate got cmd=%b addr=%h ba=%b busy=%b flag=%b exp cmd=10111 addr=000 ba=00 busy=1 flag=0",
               cmd_def, addr_def, ba_def, busy_def, flag_def);
    end
    @(negedge clk);
    rst_def = 1'b0;
    for (int k = 1; k <= 4003; k++) begin
      @(posedge clk);
      @(negedge clk);
      e_cmd  = (k == 4001) ? PREC : (k == 4003) ? AREF : NOP;
      e_addr = (k == 4001) ? 12'h400 : 12'h000;
      n_tests++;
      if ({cmd_def, addr_def, ba_def, busy_def, flag_def} !== {e_cmd, e_addr, 2'b00, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL abort_restart cyc=%0d got cmd=%b addr=%h ba=%b busy=%b flag=%b exp cmd=%b addr=%h ba=00 busy=1 flag=0",
                 k, cmd_def, addr_def, ba_def, busy_def, flag_def, e_cmd, e_addr);
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_def  = 1'b1;
    rst_fast = 1'b1;
    rst_emrs = 1'b1;
    req_def  = 1'b0;
    req_fast = 1'b0;
    req_emrs = 1'b0;
    test_reset();
    test_power_up();
    test_reinit();
    test_reset_abort();
    test_fast_timing();
    test_emrs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
